// File: rtl/qreg_serial_tx.sv
// rtl/qreg_serial_tx.sv - qreg byte FIFO feeding an async serial transmitter
//
// Purpose: every byte the CPU writes to qreg (load strobe) is queued in a
// small FIFO and shifted out on tx as an async frame, LSB first:
// 8N1 by default, 8E1 when the macro QREG_TX_PARITY_EN is defined.
//
// Ports:
//   clk      in   system clock, all state updates on posedge
//   reset    in   synchronous active-high reset (also aborts a frame)
//   load     in   one-cycle strobe, qreg written this cycle
//   data     in   byte to enqueue, sampled when load=1
//   tx       out  registered serial line, idles high
//   busy     out  1 while a frame is being shifted
//   full     out  FIFO holds FIFO_DEPTH bytes
//   empty    out  FIFO holds no bytes
//   count    out  bytes currently queued
//   overflow out  sticky, a load arrived while full and was dropped
//
// Parameters: CLKS_PER_BIT (1..255), FIFO_DEPTH (power of two, >= 2).

module qreg_serial_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              load,
    input  logic [7:0]                        data,
    output logic                              tx,
    output logic                              busy,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              overflow
);

    localparam int              CW      = $clog2(FIFO_DEPTH + 1);
    localparam int              PW      = $clog2(FIFO_DEPTH);
    localparam logic [7:0]      CNT_MAX = 8'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef QREG_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic [7:0]      clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            push;
    logic            pop;
    logic            bit_end;
    logic [2:0]      next_idx;

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        // A pop in the same cycle never frees room for a load: full_q decides.
        push       = load && !full_q;
        bit_end    = (clk_cnt_q == CNT_MAX);
        next_idx   = bit_idx_q + 3'd1;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (!empty_q) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    state_d   = START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                    clk_cnt_d = 8'd0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    clk_cnt_d = 8'd0;
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_d = 8'd0;
                    if (bit_idx_q == 3'd7) begin
`ifdef QREG_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = ^shift_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = next_idx;
                        tx_d      = shift_q[next_idx];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
`ifdef QREG_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d   = STOP;
                    tx_d      = 1'b1;
                    clk_cnt_d = 8'd0;
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    clk_cnt_d = 8'd0;
                    // Chain straight into the next frame when a byte is waiting.
                    if (!empty_q) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        full_d     = (count_d == DEPTH_C);
        empty_d    = (count_d == '0);
        overflow_d = overflow_q | (load & full_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            clk_cnt_q  <= 8'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            if (push) begin
                mem_q[wr_ptr_q] <= data;
            end
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_qreg_serial_tx.sv
// tb/tb_qreg_serial_tx.sv - scoreboard bench decoding the qreg_serial_tx pin

module tb_qreg_serial_tx;

`ifdef QREG_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] data;
    logic       tx;
    logic       busy;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       overflow;

    int checks   = 0;
    int failures = 0;
    int frames   = 0;
    int pushed   = 0;
    int rst_cnt  = 0;
    logic [7:0] exp_q [$];

    qreg_serial_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .data     (data),
        .tx       (tx),
        .busy     (busy),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (reset) rst_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit expect_out);
        load = 1'b1;
        data = b;
        if (expect_out) begin
            exp_q.push_back(b);
            pushed++;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || !empty) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_budget", 32'(n < budget), 32'd1);
    endtask

    // Monitor: decodes frames from the pin, popping the scoreboard per frame.
    initial begin : monitor
        logic [7:0] b;
        logic       p;
        logic       s;
        int         snap;
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) begin
                snap = rst_cnt;
                repeat (2) @(negedge clk);
                if (rst_cnt == snap) check("mon_start_bit", 32'(tx), 32'd0);
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    b[k] = tx;
                end
                p = 1'b0;
`ifdef QREG_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                p = tx;
`endif
                repeat (CPB) @(negedge clk);
                s = tx;
                if (rst_cnt == snap) begin
                    frames++;
                    if (exp_q.size() == 0) begin
                        check("mon_unexpected_frame", 32'(b), 32'hFFFF);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        check("mon_byte", 32'(b), 32'(e));
                        check("mon_stop_bit", 32'(s), 32'd1);
`ifdef QREG_TX_PARITY_EN
                        check("mon_parity", 32'(p), 32'(^e));
`else
                        if (p !== 1'b0) check("mon_parity_unused", 32'(p), 32'd0);
`endif
                    end
                end
            end
        end
    end

    initial begin : stim
        int         peak;
        int         run;
        int         lows;
        int         n;
        logic [7:0] a5;
        reset = 1'b1;
        load  = 1'b0;
        data  = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_state", {27'd0, tx, busy, empty, count == 3'd0, overflow},
                  {27'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
        end

        // Single byte A5: exact pin timing.
        a5 = 8'hA5;
        @(negedge clk); send(a5, 1'b1);
        @(negedge clk); load = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("a5_start", 32'(tx), 32'd0);
        end
        for (int b = 0; b < 8; b++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                check("a5_data", 32'(tx), 32'(a5[b]));
            end
        end
`ifdef QREG_TX_PARITY_EN
        for (int c = 0; c < CPB; c++) begin
            @(negedge clk);
            check("a5_parity", 32'(tx), 32'd0);
        end
`endif
        for (int c = 0; c < CPB; c++) begin
            @(negedge clk);
            check("a5_stop", 32'(tx), 32'd1);
        end
        check("a5_busy_last_stop", 32'(busy), 32'd1);
        @(negedge clk);
        check("a5_busy_after", 32'(busy), 32'd0);

        // Three back-to-back bytes.
        peak = 0;
        run  = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (busy) run++;
            if (int'(count) > peak) peak = int'(count);
            send(8'(i + 1), 1'b1);
        end
        @(negedge clk);
        if (busy) run++;
        if (int'(count) > peak) peak = int'(count);
        load = 1'b0;
        n = 0;
        while ((busy || !empty) && n < 400) begin
            @(negedge clk);
            if (busy) run++;
            if (int'(count) > peak) peak = int'(count);
            n++;
        end
        check("b2b_drain", 32'(n < 400), 32'd1);
        check("b2b_count_peak", 32'(peak), 32'd2);
        check("b2b_busy_run", 32'(run), 32'(3 * FRAME_BITS * CPB));

        // Overflow: six loads, one pops, four queue, sixth dropped.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            send(8'h10 + 8'(i), i < 5);
        end
        @(negedge clk); load = 1'b0;
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_overflow", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd4);
        wait_idle(1200);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_empty_after", 32'(empty), 32'd1);

        // Reset during DATA bit 3 aborts the frame and flushes the queue.
        @(negedge clk); send(8'h3C, 1'b0);
        @(negedge clk); send(8'hC3, 1'b0);
        @(negedge clk); load = 1'b0;
        check("rst_pre_count", 32'(count), 32'd1);
        repeat (16) @(negedge clk);
        check("rst_pre_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_state", {27'd0, tx, busy, empty, count == 3'd0, overflow},
              {27'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
        reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("rst_no_more_output", 32'(lows), 32'd0);

`ifdef QREG_TX_PARITY_EN
        run = 0;
        @(negedge clk); send(8'h07, 1'b1);
        @(negedge clk); load = 1'b0;
        n = 0;
        while ((busy || !empty) && n < 200) begin
            @(negedge clk);
            if (busy) run++;
            n++;
        end
        check("par_frame_len", 32'(run), 32'd44);
        @(negedge clk); send(8'h03, 1'b1);
        @(negedge clk); load = 1'b0;
        wait_idle(200);
`endif

        // Let the monitor finish its last frame, then reconcile.
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        check("sb_frame_count", 32'(frames), 32'(pushed));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
